// File: rtl/div_result_stage.sv
// div_result_stage: holds operands on an external combinational divider for a fixed
// settle window, then captures quotient/remainder into LO/HI and pulses done.
module div_result_stage #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] hi_out,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);
   localparam int CW = $clog2(SETTLE_CYCLES) + 1;
   typedef enum logic {IDLE, SETTLE} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
   logic             done_q, done_d, dbz_q, dbz_d;
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end
   // Operands change only on an accepted start, which keeps the divider path stable.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      if (state_q == IDLE && start) begin
         a_d     = a_in;
         b_d     = b_in;
         count_d = CW'(SETTLE_CYCLES - 1);
         state_d = SETTLE;
      end else if (state_q == SETTLE) begin
         if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end else begin
            lo_d    = div_q;
            hi_d    = div_r;
            dbz_d   = (b_q == '0);
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end
   always_comb begin
      busy        = (state_q == SETTLE);
      done        = done_q;
      div_by_zero = dbz_q;
      div_a       = a_q;
      div_b       = b_q;
      lo_out      = lo_q;
      hi_out      = hi_q;
   end
endmodule

// File: tb/tb_div_result_stage.sv
// tb_div_result_stage: random and directed requests against a divider model; a scoreboard
// queue of expected completions is consumed by an independent monitor.
module tb_div_result_stage;
   localparam int S = 4;
   logic        clock, clear, start;
   logic [31:0] a_in, b_in, div_a, div_b, div_q, div_r, lo_out, hi_out;
   logic        busy, done, div_by_zero;

   div_result_stage #(.WIDTH(32), .SETTLE_CYCLES(S)) dut (
      .clock(clock), .clear(clear), .start(start), .a_in(a_in), .b_in(b_in),
      .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
      .lo_out(lo_out), .hi_out(hi_out), .busy(busy), .done(done),
      .div_by_zero(div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Divider behaviour: signed truncating division, b==0 yields all ones for both results.
   function automatic logic [63:0] dref(logic [31:0] a, logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = '1;
         r = '1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end
      return {r, q};
   endfunction

   assign {div_r, div_q} = dref(div_a, div_b);

   typedef struct {
      int          de;
      logic [31:0] lo, hi, a;
      logic        dbz;
   } exp_t;
   exp_t        sb[$];
   int          edge_n = -1, free_e = 0, busy_end = -1, clr_e = -2;
   bit          armed = 0;
   logic [31:0] m_a = 0, m_b = 0, e_lo = 0, e_hi = 0;
   logic        e_dbz = 0;
   int          errors = 0, checks = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d got=%h expected=%h", n, edge_n, act, exp);
      end
   endtask

   // Reference model: a request is accepted when no operation is in flight, and its
   // result becomes visible exactly S edges after acceptance.
   always @(posedge clock) begin
      edge_n++;
      if (clear) begin
         sb.delete();
         free_e   = edge_n + 1;
         busy_end = -1;
         clr_e    = edge_n;
         m_a      = 0;
         m_b      = 0;
         armed    = 1;
      end else if (start && edge_n >= free_e) begin
         logic [63:0] rq;
         rq = dref(a_in, b_in);
         sb.push_back('{de: edge_n + S, lo: rq[31:0], hi: rq[63:32], a: a_in, dbz: (b_in == 0)});
         m_a      = a_in;
         m_b      = b_in;
         free_e   = edge_n + S + 1;
         busy_end = edge_n + S - 1;
      end
   end

   always @(negedge clock) begin
      if (armed) begin
         bit exp_done;
         if (clr_e == edge_n) begin
            e_lo  = 0;
            e_hi  = 0;
            e_dbz = 0;
         end
         exp_done = sb.size() > 0 && sb[0].de == edge_n;
         chk("done", {31'd0, done}, {31'd0, exp_done});
         if (exp_done) begin
            exp_t e;
            e = sb.pop_front();
            e_lo  = e.lo;
            e_hi  = e.hi;
            e_dbz = e.dbz;
            chk("div_a_at_done", div_a, e.a);
         end
         chk("lo", lo_out, e_lo);
         chk("hi", hi_out, e_hi);
         chk("dbz", {31'd0, div_by_zero}, {31'd0, e_dbz});
         chk("busy", {31'd0, busy}, {31'd0, edge_n <= busy_end});
         chk("div_a", div_a, m_a);
         chk("div_b", div_b, m_b);
      end
   end

   task automatic cyc(logic st, logic [31:0] a, logic [31:0] b, logic clr);
      @(negedge clock);
      start = st;
      a_in  = a;
      b_in  = b;
      clear = clr;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, $urandom, $urandom, 0);
   endtask

   initial begin
      start = 0;
      clear = 1;
      a_in  = 0;
      b_in  = 0;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 100, 7, 0);
      idle(S + 2);
      cyc(1, 32'hFFFF_FF9C, 7, 0);
      idle(S + 2);
      cyc(1, 5, 0, 0);
      idle(S + 2);
      cyc(1, 9, 3, 0);
      idle(S + 2);
      cyc(1, 100, 7, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 1, 1, 0);
      idle(S + 2);
      cyc(1, 100, 7, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      idle(S + 3);
      for (int i = 0; i < 20; i++) cyc(1, $urandom, $urandom_range(0, 3) == 0 ? 0 : $urandom, 0);
      idle(S + 2);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] b;
         b = $urandom_range(0, 4) == 0 ? 32'($urandom_range(0, 2)) : $urandom;
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) ? $urandom : 32'h8000_0000, b,
             $urandom_range(0, 49) == 0);
      end
      idle(S + 2);
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
